// File: rtl/vga_tile_timing.sv
// vga_tile_timing: VGA raster timing generator with tile-grid tracking.
// Produces h/v sync, active-video, pixel coordinates, tile (cell)
// coordinates, a frame-start pulse and a frame-divided game tick. All
// outputs are registered one cycle behind the raster counters.
// Optional build macro VGA_TILE_SYNC_DELAY_EN: sync and active take two
// extra register stages (3-cycle latency) so they line up with a 2-stage
// lookup that is driven by the coordinate outputs.
module vga_tile_timing #(
  parameter int H_SYNC      = 92,
  parameter int H_BP        = 50,
  parameter int H_DISP      = 640,
  parameter int H_FP        = 18,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_DISP      = 480,
  parameter int V_FP        = 10,
  parameter int TILE_W      = 32,
  parameter int TILE_H      = 32,
  parameter bit SYNC_POL    = 1'b0,
  parameter int TICK_FRAMES = 30,
  parameter int CX_W        = 5,
  parameter int CY_W        = 4
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  output logic            o_HSync,
  output logic            o_VSync,
  output logic            o_Active,
  output logic [9:0]      o_Px_X,
  output logic [9:0]      o_Px_Y,
  output logic [CX_W-1:0] o_Cell_X,
  output logic [CY_W-1:0] o_Cell_Y,
  output logic            o_Frame_Start,
  output logic            o_Game_Tick
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int H_W  = $clog2(H_TOTAL);
  localparam int V_W  = $clog2(V_TOTAL);
  localparam int TX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int TY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int FC_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [H_W-1:0]  H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]  H_SYNC_END = H_W'(H_SYNC);
  localparam logic [H_W-1:0]  H_ACT_S    = H_W'(H_SYNC + H_BP);
  localparam logic [H_W-1:0]  H_ACT_E    = H_W'(H_SYNC + H_BP + H_DISP);
  localparam logic [V_W-1:0]  V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]  V_SYNC_END = V_W'(V_SYNC);
  localparam logic [V_W-1:0]  V_ACT_S    = V_W'(V_SYNC + V_BP);
  localparam logic [V_W-1:0]  V_ACT_E    = V_W'(V_SYNC + V_BP + V_DISP);
  localparam logic [TX_W-1:0] TX_LAST    = TX_W'(TILE_W - 1);
  localparam logic [TY_W-1:0] TY_LAST    = TY_W'(TILE_H - 1);
  localparam logic [FC_W-1:0] FC_LAST    = FC_W'(TICK_FRAMES - 1);

  // Elaboration-time sanity checks on the configuration.
  if (H_DISP % TILE_W != 0) begin : g_bad_tile_w
    $error("TILE_W must divide H_DISP");
  end
  if (V_DISP % TILE_H != 0) begin : g_bad_tile_h
    $error("TILE_H must divide V_DISP");
  end
  if ((H_DISP / TILE_W - 1) >= (1 << CX_W)) begin : g_bad_cx_w
    $error("CX_W too small for the tile column count");
  end
  if ((V_DISP / TILE_H - 1) >= (1 << CY_W)) begin : g_bad_cy_w
    $error("CY_W too small for the tile row count");
  end
  if (TICK_FRAMES < 1) begin : g_bad_tick
    $error("TICK_FRAMES must be at least 1");
  end
  if (H_DISP > 1024 || V_DISP > 1024) begin : g_bad_disp
    $error("pixel coordinates are 10 bits wide");
  end

  logic [H_W-1:0]  h_cnt;
  logic [V_W-1:0]  v_cnt;
  logic [TX_W-1:0] tx;
  logic [TY_W-1:0] ty;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic [FC_W-1:0] fc;

  // Decode of the current raster position (before the next edge).
  logic h_wrap, v_wrap, h_act, v_act, h_sync_on, v_sync_on;
  logic tick_event, tick_hit;
  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign h_act      = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign v_act      = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign h_sync_on  = (h_cnt < H_SYNC_END);
  assign v_sync_on  = (v_cnt < V_SYNC_END);
  assign tick_event = (h_cnt == '0) && (v_cnt == V_ACT_E);
  assign tick_hit   = tick_event && (fc == FC_LAST);

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end
  end

  // Tile column: held at 0 outside the active span, steps every TILE_W pixels.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx <= '0;
      cx <= '0;
    end else if (!h_act) begin
      tx <= '0;
      cx <= '0;
    end else if (tx == TX_LAST) begin
      tx <= '0;
      cx <= cx + 1'b1;
    end else begin
      tx <= tx + 1'b1;
    end
  end

  // Tile row: updated only at line wrap so it is stable across a whole line.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ty <= '0;
      cy <= '0;
    end else if (h_wrap) begin
      if (!v_act) begin
        ty <= '0;
        cy <= '0;
      end else if (ty == TY_LAST) begin
        ty <= '0;
        cy <= cy + 1'b1;
      end else begin
        ty <= ty + 1'b1;
      end
    end
  end

  // Frame counter for the game tick, advanced on the first front-porch line.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) fc <= '0;
    else if (tick_event) fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
  end

  // Registered coordinate and pulse outputs (1-cycle latency).
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Px_X        <= '0;
      o_Px_Y        <= '0;
      o_Cell_X      <= '0;
      o_Cell_Y      <= '0;
      o_Frame_Start <= 1'b0;
      o_Game_Tick   <= 1'b0;
    end else begin
      o_Px_X        <= (h_act && v_act) ? 10'(h_cnt - H_ACT_S) : '0;
      o_Px_Y        <= v_act ? 10'(v_cnt - V_ACT_S) : '0;
      o_Cell_X      <= h_act ? cx : '0;
      o_Cell_Y      <= v_act ? cy : '0;
      o_Frame_Start <= (h_cnt == '0) && (v_cnt == '0);
      o_Game_Tick   <= tick_hit;
    end
  end

`ifdef VGA_TILE_SYNC_DELAY_EN
  logic [2:0] hs_pipe, vs_pipe, act_pipe;

  // Sync/active shift registers: 3 stages total, reset to deasserted.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hs_pipe  <= {3{~SYNC_POL}};
      vs_pipe  <= {3{~SYNC_POL}};
      act_pipe <= '0;
    end else begin
      hs_pipe  <= {hs_pipe[1:0], h_sync_on ? SYNC_POL : ~SYNC_POL};
      vs_pipe  <= {vs_pipe[1:0], v_sync_on ? SYNC_POL : ~SYNC_POL};
      act_pipe <= {act_pipe[1:0], h_act && v_act};
    end
  end

  assign o_HSync  = hs_pipe[2];
  assign o_VSync  = vs_pipe[2];
  assign o_Active = act_pipe[2];
`else
  // Sync/active registers with the same 1-cycle latency as the coordinates.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_HSync  <= ~SYNC_POL;
      o_VSync  <= ~SYNC_POL;
      o_Active <= 1'b0;
    end else begin
      o_HSync  <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      o_VSync  <= v_sync_on ? SYNC_POL : ~SYNC_POL;
      o_Active <= h_act && v_act;
    end
  end
`endif

endmodule

// File: tb/tb_vga_tile_timing.sv
// Bench for vga_tile_timing using a reduced raster (25 x 14) so whole
// frames fit in a short run. Expected values come from a position-based
// arithmetic model plus a hand-computed vector table.
module tb_vga_tile_timing;

  localparam int  HSYNC = 4, HBP = 3, HDISP = 16, HFP = 2;
  localparam int  VSYNC = 2, VBP = 2, VDISP = 8,  VFP = 2;
  localparam int  TW = 4, TH = 2, TF = 2;
  localparam int  CX_W = 2, CY_W = 2;
  localparam bit  POL = 1'b0;
  localparam int  HT = HSYNC + HBP + HDISP + HFP;
  localparam int  VT = VSYNC + VBP + VDISP + VFP;
  localparam int  HS0 = HSYNC + HBP;
  localparam int  VS0 = VSYNC + VBP;
  localparam int  VFP0 = VS0 + VDISP;

  typedef struct packed {
    logic            hs, vs, act;
    logic [9:0]      px, py;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            fs, gt;
  } exp_t;

  typedef struct {
    int   p;
    exp_t e;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hsync, vsync, active, frame_start, game_tick;
  logic [9:0]      px_x, px_y;
  logic [CX_W-1:0] cell_x;
  logic [CY_W-1:0] cell_y;

  int checks = 0;
  int errors = 0;
  int pos = 0;

  vga_tile_timing #(
    .H_SYNC(HSYNC), .H_BP(HBP), .H_DISP(HDISP), .H_FP(HFP),
    .V_SYNC(VSYNC), .V_BP(VBP), .V_DISP(VDISP), .V_FP(VFP),
    .TILE_W(TW), .TILE_H(TH), .SYNC_POL(POL), .TICK_FRAMES(TF),
    .CX_W(CX_W), .CY_W(CY_W)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .o_HSync(hsync), .o_VSync(vsync), .o_Active(active),
    .o_Px_X(px_x), .o_Px_Y(px_y),
    .o_Cell_X(cell_x), .o_Cell_Y(cell_y),
    .o_Frame_Start(frame_start), .o_Game_Tick(game_tick)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic exp_t mk(logic hs, logic vs, logic act, int px, int py,
                              int cx, int cy, logic fs, logic gt);
    exp_t e;
    e.hs = hs; e.vs = vs; e.act = act;
    e.px = 10'(px); e.py = 10'(py);
    e.cx = CX_W'(cx); e.cy = CY_W'(cy);
    e.fs = fs; e.gt = gt;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    return mk(!POL, !POL, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endfunction

  // Output state for raster position p (0 = first edge after reset release).
  function automatic exp_t raw(int p);
    int h, v;
    bit ha, va;
    exp_t e;
    h  = p % HT;
    v  = (p / HT) % VT;
    ha = (h >= HS0) && (h < HS0 + HDISP);
    va = (v >= VS0) && (v < VS0 + VDISP);
    e.hs  = (h < HSYNC) ? POL : !POL;
    e.vs  = (v < VSYNC) ? POL : !POL;
    e.act = ha && va;
    e.px  = (ha && va) ? 10'(h - HS0) : 10'd0;
    e.py  = va ? 10'(v - VS0) : 10'd0;
    e.cx  = ha ? CX_W'((h - HS0) / TW) : '0;
    e.cy  = va ? CY_W'((v - VS0) / TH) : '0;
    e.fs  = (h == 0) && (v == 0);
    e.gt  = (h == 0) && (v == VFP0) && ((((p / (HT * VT)) + 1) % TF) == 0);
    return e;
  endfunction

  function automatic exp_t model(int p);
    exp_t e;
    e = raw(p);
`ifdef VGA_TILE_SYNC_DELAY_EN
    if (p < 2) begin
      e.hs = !POL; e.vs = !POL; e.act = 1'b0;
    end else begin
      e.hs = raw(p - 2).hs; e.vs = raw(p - 2).vs; e.act = raw(p - 2).act;
    end
`endif
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.hs = hsync; a.vs = vsync; a.act = active;
    a.px = px_x; a.py = px_y; a.cx = cell_x; a.cy = cell_y;
    a.fs = frame_start; a.gt = game_tick;
    return a;
  endfunction

  // Scoreboard compare of the full output state.
  task automatic check(string name, exp_t e);
    exp_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s pos=%0d got hs=%b vs=%b act=%b px=%0d py=%0d cx=%0d cy=%0d fs=%b gt=%b want hs=%b vs=%b act=%b px=%0d py=%0d cx=%0d cy=%0d fs=%b gt=%b",
               name, pos, a.hs, a.vs, a.act, a.px, a.py, a.cx, a.cy, a.fs, a.gt,
               e.hs, e.vs, e.act, e.px, e.py, e.cx, e.cy, e.fs, e.gt);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Driver: one clock, then compare against the model at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("model", model(pos));
    pos++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_async", rst_exp());
    repeat (2) @(negedge clk);
    check("reset_hold", rst_exp());
    rst_n = 1'b1;
    pos = 0;
  endtask

  vec_t vecs[14];

  initial begin
    int first_tick, last_tick, n_ticks, k;

    //           hs    vs    act   px  py cx cy fs    gt
    vecs[0]  = '{0,   mk(1'b0, 1'b0, 1'b0, 0,  0, 0, 0, 1'b1, 1'b0)};
    vecs[1]  = '{4,   mk(1'b1, 1'b0, 1'b0, 0,  0, 0, 0, 1'b0, 1'b0)};
    vecs[2]  = '{40,  mk(1'b1, 1'b0, 1'b0, 0,  0, 2, 0, 1'b0, 1'b0)};
    vecs[3]  = '{50,  mk(1'b0, 1'b1, 1'b0, 0,  0, 0, 0, 1'b0, 1'b0)};
    vecs[4]  = '{107, mk(1'b1, 1'b1, 1'b1, 0,  0, 0, 0, 1'b0, 1'b0)};
    vecs[5]  = '{111, mk(1'b1, 1'b1, 1'b1, 4,  0, 1, 0, 1'b0, 1'b0)};
    vecs[6]  = '{122, mk(1'b1, 1'b1, 1'b1, 15, 0, 3, 0, 1'b0, 1'b0)};
    vecs[7]  = '{123, mk(1'b1, 1'b1, 1'b0, 0,  0, 0, 0, 1'b0, 1'b0)};
    vecs[8]  = '{160, mk(1'b1, 1'b1, 1'b1, 3,  2, 0, 1, 1'b0, 1'b0)};
    vecs[9]  = '{177, mk(1'b0, 1'b1, 1'b0, 0,  3, 0, 1, 1'b0, 1'b0)};
    vecs[10] = '{297, mk(1'b1, 1'b1, 1'b1, 15, 7, 3, 3, 1'b0, 1'b0)};
    vecs[11] = '{300, mk(1'b0, 1'b1, 1'b0, 0,  0, 0, 0, 1'b0, 1'b0)};
    vecs[12] = '{350, mk(1'b0, 1'b0, 1'b0, 0,  0, 0, 0, 1'b1, 1'b0)};
    vecs[13] = '{650, mk(1'b0, 1'b1, 1'b0, 0,  0, 0, 0, 1'b0, 1'b1)};

    // Reset held from time 0
    repeat (3) @(negedge clk);
    check("reset_initial", rst_exp());

    // Table-driven vectors: reset, run to the recorded position, compare.
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      do_reset();
      repeat (vecs[i].p + 1) step();
      e = vecs[i].e;
`ifdef VGA_TILE_SYNC_DELAY_EN
      e.hs = model(vecs[i].p).hs;
      e.vs = model(vecs[i].p).vs;
      e.act = model(vecs[i].p).act;
`endif
      check($sformatf("vec%0d", i), e);
    end

    // Game tick spacing over five frames.
    do_reset();
    first_tick = -1; last_tick = -1; n_ticks = 0;
    repeat (5 * HT * VT) begin
      step();
      if (game_tick === 1'b1) begin
        if (first_tick < 0) first_tick = pos - 1;
        last_tick = pos - 1;
        n_ticks++;
      end
    end
    check_int("tick_count", n_ticks, 2);
    check_int("tick_first", first_tick, TF * HT * VT - (VT - VFP0) * HT);
    check_int("tick_spacing", last_tick - first_tick, TF * HT * VT);

    // Random mid-frame asynchronous resets.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      k = $urandom_range(20, 3 * HT * VT);
      repeat (k) step();
      #2 rst_n = 1'b0;
      #1 check("reset_mid_async", rst_exp());
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check("reset_mid_hold", rst_exp());
      rst_n = 1'b1;
      pos = 0;
      step();
      check_int("restart_frame_start", int'(frame_start), 1);
      repeat ($urandom_range(30, 2 * HT)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
